// File: rtl/dct_pkg.sv
// Shared types, constants and the Q.12 DCT-II coefficient ROM for the 1-D DCT sequencer.
package dct_pkg;
    localparam int DCT_N         = 8;
    localparam int DCT_FRAC_BITS = 12;
    localparam int DCT_W         = 32;
    localparam int DCT_COEFF_W   = 16;

    typedef logic signed [DCT_W-1:0]       dct_lane_t;
    typedef dct_lane_t [DCT_N-1:0]         dct_vec_t;
    typedef logic signed [DCT_COEFF_W-1:0] dct_coeff_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_HOLD
    } dct_seq_state_e;

    // Row k, lane i: round(4096 * a_k * cos((2i+1)k*pi/16)), a_0 = sqrt(1/8), a_k = 0.5 otherwise.
    localparam dct_coeff_t DCT_COEFF [DCT_N][DCT_N] = '{
        '{ 16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448},
        '{ 16'sd2009,  16'sd1703,  16'sd1138,  16'sd400,  -16'sd400,  -16'sd1138, -16'sd1703, -16'sd2009},
        '{ 16'sd1892,  16'sd784,  -16'sd784,  -16'sd1892, -16'sd1892, -16'sd784,   16'sd784,   16'sd1892},
        '{ 16'sd1703, -16'sd400,  -16'sd2009, -16'sd1138,  16'sd1138,  16'sd2009,  16'sd400,  -16'sd1703},
        '{ 16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448,  16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448},
        '{ 16'sd1138, -16'sd2009,  16'sd400,   16'sd1703, -16'sd1703, -16'sd400,   16'sd2009, -16'sd1138},
        '{ 16'sd784,  -16'sd1892,  16'sd1892, -16'sd784,  -16'sd784,   16'sd1892, -16'sd1892,  16'sd784 },
        '{ 16'sd400,  -16'sd1138,  16'sd1703, -16'sd2009,  16'sd2009, -16'sd1703,  16'sd1138, -16'sd400 }
    };
endpackage

// File: rtl/dct_lane_sum.sv
// Combinational 8-lane signed adder tree; lanes are sign-extended to ACC_W so the sum cannot overflow.
module dct_lane_sum
    import dct_pkg::*;
#(
    parameter int LANE_W = 32,
    parameter int ACC_W  = LANE_W + 3
) (
    input  logic [DCT_N*LANE_W-1:0] lanes_dat,
    output logic signed [ACC_W-1:0] sum_dat
);
    logic signed [ACC_W-1:0] ext  [DCT_N];
    logic signed [ACC_W-1:0] lvl1 [DCT_N/2];
    logic signed [ACC_W-1:0] lvl2 [DCT_N/4];

    always_comb begin
        for (int i = 0; i < DCT_N; i++) begin
            ext[i] = ACC_W'($signed(lanes_dat[i*LANE_W +: LANE_W]));
        end
        for (int j = 0; j < DCT_N/2; j++) begin
            lvl1[j] = ext[2*j] + ext[2*j+1];
        end
        for (int j = 0; j < DCT_N/4; j++) begin
            lvl2[j] = lvl1[2*j] + lvl1[2*j+1];
        end
        sum_dat = lvl2[0] + lvl2[1];
    end
endmodule

// File: rtl/dct_1d_seq.sv
// dct_1d_seq: 8-point 1-D DCT sequencer over dct_1d; 10+DCT_LAT cycles per vector, in_ready low until the result handshakes.
// DCT_SEQ_ROUND_EN: round half up before the Q.12 shift (truncates toward -inf when undefined).
module dct_1d_seq
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8,
    parameter int FRAC_BITS  = DCT_FRAC_BITS,
    parameter int DCT_LAT    = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] out_data,
    output logic                             dct_reset_n,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] dct_data,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] dct_coeff,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] dct_result
);
    localparam int ACC_W = DATA_WIDTH + 3;
    localparam int RW    = ACC_W + 1;
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`ifdef DCT_SEQ_ROUND_EN
    localparam logic signed [RW-1:0] RND_BIAS = RW'(2**(FRAC_BITS-1));
`endif

    dct_seq_state_e                         state_q, state_d;
    logic [2:0]                             k_q, k_d;
    logic [DATA_WIDTH*DATA_DEPTH-1:0]       data_q, data_d;
    logic [DCT_LAT-1:0]                     tag_vld_q, tag_vld_d;
    logic [DCT_LAT-1:0][2:0]                tag_k_q, tag_k_d;
    logic [DCT_N-1:0][DATA_WIDTH-1:0]       res_q, res_d;
    logic                                   out_valid_q, out_valid_d;

    logic signed [ACC_W-1:0]                lane_sum;
    logic signed [RW-1:0]                   sum_rnd;
    logic signed [RW-1:0]                   sum_shr;
    logic [DATA_WIDTH-1:0]                  lane_sat;

    dct_lane_sum #(.LANE_W(DATA_WIDTH), .ACC_W(ACC_W)) u_lane_sum (
        .lanes_dat (dct_result),
        .sum_dat   (lane_sum)
    );

    always_comb begin
`ifdef DCT_SEQ_ROUND_EN
        sum_rnd = {lane_sum[ACC_W-1], lane_sum} + RND_BIAS;
`else
        sum_rnd = {lane_sum[ACC_W-1], lane_sum};
`endif
        sum_shr = sum_rnd >>> FRAC_BITS;
        if (sum_shr > SAT_MAX) begin
            lane_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sum_shr < SAT_MIN) begin
            lane_sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            lane_sat = sum_shr[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        data_d      = data_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;

        // Each issued beat carries its row index down a DCT_LAT-deep pipe to meet its product.
        tag_vld_d[0] = (state_q == ST_ISSUE);
        tag_k_d[0]   = k_q;
        for (int i = 1; i < DCT_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_k_d[i]   = tag_k_q[i-1];
        end
        if (tag_vld_q[DCT_LAT-1]) begin
            res_d[tag_k_q[DCT_LAT-1]] = lane_sat;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    k_d     = 3'd0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!(|tag_vld_q)) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= 3'd0;
            data_q      <= '0;
            tag_vld_q   <= '0;
            tag_k_q     <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            data_q      <= data_d;
            tag_vld_q   <= tag_vld_d;
            tag_k_q     <= tag_k_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        dct_data  = '0;
        dct_coeff = '0;
        if (state_q == ST_ISSUE) begin
            dct_data = data_q;
            for (int i = 0; i < DCT_N; i++) begin
                dct_coeff[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(DCT_COEFF[k_q][i]);
            end
        end
    end

    assign in_ready    = (state_q == ST_IDLE) && !reset;
    assign out_valid   = out_valid_q;
    assign out_data    = res_q;
    assign dct_reset_n = ~reset;
endmodule

// File: tb/tb_dct_1d_seq.sv
// Directed bench for dct_1d_seq with a behavioural one-cycle dct_1d multiplier in the loop.
module tb_dct_1d_seq;
    import dct_pkg::*;

    localparam int W = 32;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic           dct_reset_n;
    logic [N*W-1:0] dct_data;
    logic [N*W-1:0] dct_coeff;
    logic [N*W-1:0] dct_result;

    int errors = 0;
    int checks = 0;

    // Column 0 and column 1 of the coefficient matrix, and column 3 for the lane-order vector.
    int col0 [8] = '{1448, 2009, 1892, 1703, 1448, 1138, 784, 400};
    int col1 [8] = '{1448, 1703, 784, -400, -1448, -2009, -1892, -1138};
    int col3 [8] = '{1448, 400, -1892, -1138, 1448, 1703, -784, -2009};
`ifdef DCT_SEQ_ROUND_EN
    int dc_x0  = 283;
    int neg_xk = 0;
`else
    int dc_x0  = 282;
    int neg_xk = -1;
`endif

    always #5 clk = ~clk;

    dct_1d_seq #(.DATA_WIDTH(W), .DATA_DEPTH(N), .FRAC_BITS(12), .DCT_LAT(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .dct_reset_n (dct_reset_n),
        .dct_data    (dct_data),
        .dct_coeff   (dct_coeff),
        .dct_result  (dct_result)
    );

    always @(posedge clk) begin
        if (!dct_reset_n) begin
            dct_result <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                dct_result[i*W +: W] <= W'($signed(dct_data[i*W +: W]) * $signed(dct_coeff[i*W +: W]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input dct_vec_t v, output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        in_valid = 1'b1;
        in_data = v;
        for (int c = 1; c <= 40; c++) begin
            if (in_ready) ok = 1'b1;
            tick();
            cyc = c;
            if (ok) break;
        end
        in_valid = 1'b0;
        in_data = '0;
    endtask

    task automatic wait_out(output int lat, output bit ok);
        lat = 0;
        ok = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (out_valid) begin
                lat = c;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (dct_data !== '0) begin errors++; $display("FAIL reset_dct_data: got %h expected 0", dct_data); end
        checks++; if (dct_coeff !== '0) begin errors++; $display("FAIL reset_dct_coeff: got %h expected 0", dct_coeff); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (dct_reset_n !== 1'b0) begin errors++; $display("FAIL reset_dct_reset_n: got %b expected 0", dct_reset_n); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        checks++; if (dct_reset_n !== 1'b1) begin errors++; $display("FAIL release_dct_reset_n: got %b expected 1", dct_reset_n); end
    endtask

    task automatic test_impulse(input string tag);
        dct_vec_t v, r;
        int cyc, lat;
        bit ok;
        v = '0;
        v[0] = 32'sd4096;
        send_vec(v, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_accept: got timeout expected handshake", tag); return; end
        wait_out(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_out_valid: got timeout expected out_valid", tag); return; end
        checks++; if (lat != 10) begin errors++; $display("FAIL %s_latency: got %0d expected 10", tag, lat); end
        r = out_data;
        for (int k = 0; k < N; k++) begin
            checks++; if (r[k] !== col0[k]) begin errors++; $display("FAIL %s_x%0d: got %0d expected %0d", tag, k, r[k], col0[k]); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_release_valid: got %b expected 0", tag, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_release_ready: got %b expected 1", tag, in_ready); end
    endtask

    task automatic test_dc();
        dct_vec_t v, r;
        int cyc, lat;
        bit ok;
        for (int i = 0; i < N; i++) v[i] = 32'sd100;
        send_vec(v, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dc_accept: got timeout expected handshake"); return; end
        wait_out(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dc_out_valid: got timeout expected out_valid"); return; end
        r = out_data;
        checks++; if (r[0] !== dc_x0) begin errors++; $display("FAIL dc_x0: got %0d expected %0d", r[0], dc_x0); end
        for (int k = 1; k < N; k++) begin
            checks++; if (r[k] !== 0) begin errors++; $display("FAIL dc_x%0d: got %0d expected 0", k, r[k]); end
        end
        tick();
    endtask

    task automatic test_lane_order();
        dct_vec_t v, r;
        int cyc, lat;
        bit ok;
        v = '0;
        v[3] = 32'sd4096;
        send_vec(v, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lane3_accept: got timeout expected handshake"); return; end
        wait_out(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lane3_out_valid: got timeout expected out_valid"); return; end
        r = out_data;
        for (int k = 0; k < N; k++) begin
            checks++; if (r[k] !== col3[k]) begin errors++; $display("FAIL lane3_x%0d: got %0d expected %0d", k, r[k], col3[k]); end
        end
        tick();
    endtask

    task automatic test_beat_order();
        dct_vec_t v, d, c;
        int cyc, lat;
        bit ok;
        for (int i = 0; i < N; i++) v[i] = 32'(i * 3 + 1);
        send_vec(v, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL beat_accept: got timeout expected handshake"); return; end
        for (int k = 0; k < N; k++) begin
            d = dct_data;
            c = dct_coeff;
            checks++; if (d !== v) begin errors++; $display("FAIL beat%0d_data: got %h expected %h", k, d, v); end
            checks++; if (c[0] !== col0[k]) begin errors++; $display("FAIL beat%0d_c0: got %0d expected %0d", k, c[0], col0[k]); end
            checks++; if (c[1] !== col1[k]) begin errors++; $display("FAIL beat%0d_c1: got %0d expected %0d", k, c[1], col1[k]); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL beat%0d_in_ready: got %b expected 0", k, in_ready); end
            tick();
        end
        checks++; if (dct_coeff !== '0) begin errors++; $display("FAIL beat_after_coeff: got %h expected 0", dct_coeff); end
        checks++; if (dct_data !== '0) begin errors++; $display("FAIL beat_after_data: got %h expected 0", dct_data); end
        wait_out(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL beat_out_valid: got timeout expected out_valid"); return; end
        checks++; if (lat != 2) begin errors++; $display("FAIL beat_drain_lat: got %0d expected 2", lat); end
        tick();
    endtask

    task automatic test_backpressure();
        dct_vec_t v1, v2, r;
        int cyc, lat;
        bit ok;
        v1 = '0;
        v1[0] = 32'sd4096;
        v2 = '0;
        v2[3] = 32'sd4096;
        out_ready = 1'b0;
        send_vec(v1, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got timeout expected handshake"); out_ready = 1'b1; return; end
        wait_out(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_out_valid: got timeout expected out_valid"); out_ready = 1'b1; return; end
        in_valid = 1'b1;
        in_data = v2;
        for (int c = 0; c < 20; c++) begin
            tick();
            r = out_data;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid_c%0d: got %b expected 1", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready_c%0d: got %b expected 0", c, in_ready); end
            checks++; if (r[1] !== col0[1] || r[7] !== col0[7]) begin errors++; $display("FAIL bp_hold_data_c%0d: got x1=%0d x7=%0d expected 2009 400", c, r[1], r[7]); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        in_data = '0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: got in_ready %b expected 0", in_ready); end
        checks++; if (dct_data !== v2) begin errors++; $display("FAIL bp_second_data: got %h expected %h", dct_data, v2); end
        wait_out(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_second_out: got timeout expected out_valid"); return; end
        checks++; if (lat != 10) begin errors++; $display("FAIL bp_second_lat: got %0d expected 10", lat); end
        r = out_data;
        for (int k = 0; k < N; k++) begin
            checks++; if (r[k] !== col3[k]) begin errors++; $display("FAIL bp_second_x%0d: got %0d expected %0d", k, r[k], col3[k]); end
        end
        tick();
    endtask

    task automatic test_mid_reset();
        dct_vec_t v, c;
        int cyc, seen;
        bit ok;
        v = '0;
        v[0] = 32'sd4096;
        send_vec(v, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_accept: got timeout expected handshake"); return; end
        repeat (4) tick();
        c = dct_coeff;
        checks++; if (c[1] !== -1448) begin errors++; $display("FAIL mid_beat4_c1: got %0d expected -1448", c[1]); end
        reset = 1'b1;
        tick();
        checks++; if (dct_coeff !== '0) begin errors++; $display("FAIL mid_coeff: got %h expected 0", dct_coeff); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_idle: got in_ready %b expected 1", in_ready); end
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_output: got %0d valid cycles expected 0", seen); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_out_data: got %h expected 0", out_data); end
        test_impulse("mid_fresh");
    endtask

    task automatic test_back_to_back();
        dct_vec_t v1, v2, r;
        int cyc, lat;
        bit ok;
        for (int i = 0; i < N; i++) v1[i] = 32'sd100;
        v2 = '0;
        v2[0] = -32'sd1;
        send_vec(v1, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_accept1: got timeout expected handshake"); return; end
        wait_out(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_out1: got timeout expected out_valid"); return; end
        r = out_data;
        checks++; if (r[0] !== dc_x0) begin errors++; $display("FAIL b2b_x0: got %0d expected %0d", r[0], dc_x0); end
        send_vec(v2, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_accept2: got timeout expected handshake"); return; end
        checks++; if (cyc != 2) begin errors++; $display("FAIL b2b_gap: got %0d cycles expected 2", cyc); end
        wait_out(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_out2: got timeout expected out_valid"); return; end
        r = out_data;
        for (int k = 0; k < N; k++) begin
            checks++; if (r[k] !== neg_xk) begin errors++; $display("FAIL neg_x%0d: got %0d expected %0d", k, r[k], neg_xk); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_impulse("impulse");
        test_dc();
        test_lane_order();
        test_beat_order();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
